shift_reg_ctrl: RTL and testbench

- Sequencer for the mode-controlled shift register (modes 0 hold, 1 parallel load, 2 shift left with D into the LSB, 3 shift right with D into the MSB).
- Accepts a transmit word on a valid/ready handshake, parallel-loads it, then issues WIDTH shift commands at a programmable bit rate.
- Each shift drives the outgoing bit on sout_o and shifts sin_i in, giving a full-duplex, SPI-like word exchange.
- Presents the received word with a one-cycle valid pulse.

---
 rtl/shift_reg_ctrl.sv | 155 +++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// Sequencer that drives a mode-controlled shift register for a full-duplex serial word exchange.
// Optional abort input is enabled by defining SHIFT_REG_CTRL_ABORT_EN.
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] tx_data_i,
`ifdef SHIFT_REG_CTRL_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             ready_o,
    output logic             busy_o,
    output logic             sout_o,
    input  logic             sin_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic [1:0]       sr_mode_o,
    output logic [WIDTH-1:0] sr_par_o,
    output logic             sr_D_o,
    input  logic [WIDTH-1:0] sr_P_i
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [1:0] M_HOLD = 2'd0;
    localparam logic [1:0] M_LOAD = 2'd1;
    localparam logic [1:0] M_SHL  = 2'd2;
    localparam logic [1:0] M_SHR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             ready_q;
    logic             dir_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic [1:0]       mode_q;
    logic [DW-1:0]    div_q;
    logic [DW-1:0]    div_d;
    logic [BW-1:0]    bit_q;
    logic             div_wrap_s;
    logic             abort_s;

    // The mode register is loaded one edge early, so it reflects the cycle whose divider value is div.
    function automatic logic [1:0] shift_cmd(input logic [DW-1:0] div, input logic dir);
        if (div == DIV_LAST) begin
            return dir ? M_SHR : M_SHL;
        end else begin
            return M_HOLD;
        end
    endfunction

`ifdef SHIFT_REG_CTRL_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    // Divider next value: count 0..DIV-1 and wrap.
    always_comb begin
        div_wrap_s = (div_q == DIV_LAST);
        if (div_wrap_s) begin
            div_d = '0;
        end else begin
            div_d = DW'(div_q + DW'(1));
        end
    end

    // Transfer sequencer with registered mode, handshake and receive outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            dir_q      <= 1'b0;
            tx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mode_q     <= M_HOLD;
            div_q      <= '0;
            bit_q      <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (abort_s && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
                mode_q  <= M_HOLD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            tx_q    <= tx_data_i;
                            dir_q   <= dir_i;
                            state_q <= S_LOAD;
                            ready_q <= 1'b0;
                            mode_q  <= M_LOAD;
                        end
                    end
                    S_LOAD: begin
                        bit_q   <= '0;
                        div_q   <= '0;
                        state_q <= S_SHIFT;
                        mode_q  <= shift_cmd('0, dir_q);
                    end
                    S_SHIFT: begin
                        div_q <= div_d;
                        if (div_wrap_s) begin
                            bit_q <= BW'(bit_q + BW'(1));
                        end
                        if (div_wrap_s && (bit_q == BIT_LAST)) begin
                            state_q <= S_DONE;
                            mode_q  <= M_HOLD;
                        end else begin
                            mode_q  <= shift_cmd(div_d, dir_q);
                        end
                    end
                    S_DONE: begin
                        rx_data_q  <= sr_P_i;
                        rx_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                        ready_q    <= 1'b1;
                        mode_q     <= M_HOLD;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        mode_q  <= M_HOLD;
                    end
                endcase
            end
        end
    end

    assign ready_o    = ready_q;
    assign busy_o     = ~ready_q;
    assign sout_o     = dir_q ? sr_P_i[0] : sr_P_i[WIDTH-1];
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign sr_mode_o  = mode_q;
    assign sr_par_o   = tx_q;
    assign sr_D_o     = sin_i;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed self-checking bench: two controllers (DIV=1 and DIV=3), each driving a behavioural shift register.
module tb_shift_reg_ctrl;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic       start1, dir1, sin1, ready1, busy1, sout1, rxv1, d1;
    logic [7:0] tx1, rx1, par1, p1;
    logic [1:0] mode1;
    logic       start2, dir2, sin2, ready2, busy2, sout2, rxv2, d2;
    logic [7:0] tx2, rx2, par2, p2;
    logic [1:0] mode2;
`ifdef SHIFT_REG_CTRL_ABORT_EN
    logic       abort1, abort2;
`endif

    int checks   = 0;
    int failures = 0;

    shift_reg_ctrl #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .nrst(nrst), .start_i(start1), .dir_i(dir1), .tx_data_i(tx1),
`ifdef SHIFT_REG_CTRL_ABORT_EN
        .abort_i(abort1),
`endif
        .ready_o(ready1), .busy_o(busy1), .sout_o(sout1), .sin_i(sin1),
        .rx_data_o(rx1), .rx_valid_o(rxv1), .sr_mode_o(mode1), .sr_par_o(par1),
        .sr_D_o(d1), .sr_P_i(p1)
    );

    shift_reg_ctrl #(.WIDTH(8), .DIV(3)) dut2 (
        .clk(clk), .nrst(nrst), .start_i(start2), .dir_i(dir2), .tx_data_i(tx2),
`ifdef SHIFT_REG_CTRL_ABORT_EN
        .abort_i(abort2),
`endif
        .ready_o(ready2), .busy_o(busy2), .sout_o(sout2), .sin_i(sin2),
        .rx_data_o(rx2), .rx_valid_o(rxv2), .sr_mode_o(mode2), .sr_par_o(par2),
        .sr_D_o(d2), .sr_P_i(p2)
    );

    // Shift register model for dut1.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) p1 <= 8'h00;
        else case (mode1)
            2'd1:    p1 <= par1;
            2'd2:    p1 <= {p1[6:0], d1};
            2'd3:    p1 <= {d1, p1[7:1]};
            default: p1 <= p1;
        endcase
    end

    // Shift register model for dut2.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) p2 <= 8'h00;
        else case (mode2)
            2'd1:    p2 <= par2;
            2'd2:    p2 <= {p2[6:0], d2};
            2'd3:    p2 <= {d2, p2[7:1]};
            default: p2 <= p2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DIV=1 transfer on dut1; returns in the rx_valid cycle (10 edges after accept).
    task automatic xfer(input logic [7:0] tx, input logic dir, input logic [7:0] sin_seq,
                        input logic [7:0] sout_exp, input logic [7:0] rx_exp,
                        input bit loopback, input bit hold_start);
        start1 = 1'b1;
        tx1    = tx;
        dir1   = dir;
        tick();
        chk("load_mode", mode1, 2'd1);
        chk("load_par", par1, tx);
        chk("load_ready_busy", {ready1, busy1}, 2'b01);
        chk("prev_valid_one_wide", rxv1, 1'b0);
        if (!hold_start) start1 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("sr_d_follows_sin", d1, sin1);
            chk("sout_bit", sout1, sout_exp[7-i]);
            chk("shift_mode", mode1, dir ? 2'd3 : 2'd2);
            sin1 = loopback ? sout1 : sin_seq[7-i];
            tick();
        end
        chk("done_mode", mode1, 2'd0);
        chk("done_no_valid", rxv1, 1'b0);
        chk("done_busy", busy1, 1'b1);
        tick();
        chk("rx_valid_latency", rxv1, 1'b1);
        chk("rx_data", rx1, rx_exp);
        chk("ready_with_valid", ready1, 1'b1);
    endtask

    int loads, shifts, bad_shifts, last_shift_k, first_shift_k, valid_k, valids;
    logic [7:0] rx_seen;

    initial begin
        nrst = 1'b0;
        start1 = 1'b0; dir1 = 1'b0; sin1 = 1'b0; tx1 = 8'h00;
        start2 = 1'b0; dir2 = 1'b0; sin2 = 1'b1; tx2 = 8'h00;
`ifdef SHIFT_REG_CTRL_ABORT_EN
        abort1 = 1'b0; abort2 = 1'b0;
`endif
        tick();
        tick();
        chk("rst_ready_busy", {ready1, busy1}, 2'b10);
        chk("rst_mode", mode1, 2'd0);
        chk("rst_par", par1, 8'h00);
        chk("rst_rx", {rx1, rxv1}, 9'h000);
        chk("rst2_state", {ready2, busy2, mode2, rxv2}, 5'b10000);
        nrst = 1'b1;
        tick();

        // MSB-first 0xA5 with start held high throughout, then back-to-back loopback of 0x3C.
        xfer(8'hA5, 1'b0, 8'b11001010, 8'b10100101, 8'hCA, 1'b0, 1'b1);
        xfer(8'h3C, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b1, 1'b0);
        tick();
        chk("valid_cleared", rxv1, 1'b0);
        chk("rx_holds", rx1, 8'h3C);

        // Reset in the middle of SHIFT.
        start1 = 1'b1; tx1 = 8'hFF; dir1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick(); tick();
        nrst = 1'b0;
        #1;
        chk("midrst_ready", ready1, 1'b1);
        chk("midrst_mode", mode1, 2'd0);
        chk("midrst_rx", {rx1, rxv1}, 9'h000);
        tick(); tick();
        chk("midrst_no_valid", rxv1, 1'b0);
        nrst = 1'b1;
        tick();

        // LSB-first 0x0F after reset release.
        xfer(8'h0F, 1'b1, 8'b01010101, 8'b11110000, 8'hAA, 1'b0, 1'b0);
        tick();

        // DIV=3 spacing and latency on dut2.
        start2 = 1'b1; tx2 = 8'h0F; dir2 = 1'b0; sin2 = 1'b1;
        tick();
        start2 = 1'b0;
        loads = 0; shifts = 0; bad_shifts = 0; last_shift_k = -1; first_shift_k = -1;
        valid_k = -1; valids = 0; rx_seen = 8'h00;
        for (int k = 0; k < 30; k++) begin
            if (mode2 == 2'd1) loads++;
            if (mode2 == 2'd3) bad_shifts++;
            if (mode2 == 2'd2) begin
                if (first_shift_k < 0) first_shift_k = k;
                if (last_shift_k >= 0 && (k - last_shift_k) != 3) bad_shifts++;
                last_shift_k = k;
                shifts++;
            end
            if (k >= 1 && k <= 24) chk("div3_sout", sout2, tx2[7 - ((k - 1) / 3)]);
            if (rxv2) begin
                valids++;
                if (valid_k < 0) begin
                    valid_k = k;
                    rx_seen = rx2;
                end
            end
            tick();
        end
        chk("div3_loads", loads, 1);
        chk("div3_shifts", shifts, 8);
        chk("div3_first_shift", first_shift_k, 3);
        chk("div3_spacing", bad_shifts, 0);
        chk("div3_latency", valid_k, 26);
        chk("div3_valid_width", valids, 1);
        chk("div3_rx", rx_seen, 8'hFF);

`ifdef SHIFT_REG_CTRL_ABORT_EN
        // Abort after three shifts on dut1.
        start1 = 1'b1; tx1 = 8'hA5; dir1 = 1'b0;
        tick();
        start1 = 1'b0;
        tick(); tick(); tick(); tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("abort_ready", ready1, 1'b1);
        chk("abort_mode", mode1, 2'd0);
        valids = 0;
        for (int k = 0; k < 12; k++) begin
            if (rxv1) valids++;
            tick();
        end
        chk("abort_no_valid", valids, 0);
        chk("abort_rx_kept", rx1, 8'hAA);
        xfer(8'hA5, 1'b0, 8'b11001010, 8'b10100101, 8'hCA, 1'b0, 1'b0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
